// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU definitions used by the hazard controller and the IF/ID register.
// Holds the controller state encoding, the x0 address and the NOP pattern.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MEM_WAIT   = 2'd1,
    FLUSH_PEND = 2'd2
  } hz_state_t;

  localparam int unsigned        REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0  = '0;
  // addi x0, x0, 0 : what IF/ID loads when it is flushed
  localparam logic [31:0]        NOP_INSTR  = 32'h0000_0013;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter: sticks at all-ones, clear beats increment.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch squash and
// memory-busy freeze, with a latched flush that survives a freeze.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] ifid_rs1_i,
  input  logic [ADDR_W-1:0] ifid_rs2_i,
  input  logic              ifid_uses_rs2_i,
  input  logic              idex_memread_i,
  input  logic [ADDR_W-1:0] idex_rd_i,
  input  logic              ex_branch_taken_i,
  input  logic              mem_busy_i,
  input  logic              cnt_clr_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              idex_flush_o,
  output logic              pipe_freeze_o,
  output logic              pc_sel_branch_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  hz_state_t state_q, state_d;
  logic      pend_q, pend_d;
  logic      load_use;
  logic      stall_inc, flush_inc;

  assign load_use = idex_memread_i && (idex_rd_i != ADDR_W'(REG_X0)) &&
                    ((idex_rd_i == ifid_rs1_i) ||
                     (ifid_uses_rs2_i && (idex_rd_i == ifid_rs2_i)));

  always_comb begin
    state_d         = state_q;
    pend_d          = pend_q;
    pc_write_o      = 1'b1;
    ifid_write_o    = 1'b1;
    ifid_flush_o    = 1'b0;
    idex_flush_o    = 1'b0;
    pipe_freeze_o   = 1'b0;
    pc_sel_branch_o = 1'b0;
    stall_inc       = 1'b0;
    flush_inc       = 1'b0;

    if (mem_busy_i) begin
      // Freeze outranks everything; a branch seen now is remembered, not applied.
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      pipe_freeze_o = 1'b1;
      pend_d        = pend_q | ex_branch_taken_i;
      state_d       = MEM_WAIT;
    end else if (state_q == FLUSH_PEND) begin
      pc_sel_branch_o = 1'b1;
      ifid_flush_o    = 1'b1;
      idex_flush_o    = 1'b1;
      flush_inc       = 1'b1;
      pend_d          = 1'b0;
      state_d         = RUN;
    end else begin
      // With pend set the branch still in EX is the one already latched.
      state_d = pend_q ? FLUSH_PEND : RUN;
      if (ex_branch_taken_i && !pend_q) begin
        pc_sel_branch_o = 1'b1;
        ifid_flush_o    = 1'b1;
        idex_flush_o    = 1'b1;
        flush_inc       = 1'b1;
      end else if (load_use) begin
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
        idex_flush_o = 1'b1;
        stall_inc    = 1'b1;
      end
    end

    if (rst_i) begin
      pc_write_o      = 1'b1;
      ifid_write_o    = 1'b1;
      ifid_flush_o    = 1'b0;
      idex_flush_o    = 1'b0;
      pipe_freeze_o   = 1'b0;
      pc_sel_branch_o = 1'b0;
      stall_inc       = 1'b0;
      flush_inc       = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_inc),
    .clr_i (cnt_clr_i),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (flush_inc),
    .clr_i (cnt_clr_i),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table for single-cycle RUN behaviour
// plus hand-written sequences for freeze, pending flush, reset and saturation.
module tb_hazard_ctrl;

  localparam int CNT_W  = 4;
  localparam int ADDR_W = 5;

  // control word order: {pc_write, ifid_write, ifid_flush, idex_flush, freeze, sel}
  localparam logic [5:0] C_EN    = 6'b110000;
  localparam logic [5:0] C_STALL = 6'b000100;
  localparam logic [5:0] C_FLUSH = 6'b111101;
  localparam logic [5:0] C_FRZ   = 6'b000010;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] rs1, rs2, rd;
  logic              uses_rs2, memread, br, busy, clr;
  logic              pc_write, ifid_write, ifid_flush, idex_flush, freeze, sel;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .ifid_rs1_i        (rs1),
    .ifid_rs2_i        (rs2),
    .ifid_uses_rs2_i   (uses_rs2),
    .idex_memread_i    (memread),
    .idex_rd_i         (rd),
    .ex_branch_taken_i (br),
    .mem_busy_i        (busy),
    .cnt_clr_i         (clr),
    .pc_write_o        (pc_write),
    .ifid_write_o      (ifid_write),
    .ifid_flush_o      (ifid_flush),
    .idex_flush_o      (idex_flush),
    .pipe_freeze_o     (freeze),
    .pc_sel_branch_o   (sel),
    .stall_cnt_o       (stall_cnt),
    .flush_cnt_o       (flush_cnt)
  );

  typedef struct {
    string      nm;
    logic [4:0] rs1, rs2;
    logic       uses, mr;
    logic [4:0] rd;
    logic       br, busy, clr;
    logic [5:0] ctl;
    logic [3:0] es, ef;
  } vec_t;

  vec_t vt[10];

  // Apply one cycle of inputs, check outputs mid-cycle, then cross the next edge.
  task automatic cyc(input string nm, input logic r,
                     input logic [4:0] a1, input logic [4:0] a2, input logic u,
                     input logic m, input logic [4:0] d, input logic b,
                     input logic bz, input logic c,
                     input logic [5:0] ctl, input logic [3:0] es, input logic [3:0] ef);
    logic [5:0] got;
    rst = r; rs1 = a1; rs2 = a2; uses_rs2 = u; memread = m; rd = d;
    br = b; busy = bz; clr = c;
    #2;
    got = {pc_write, ifid_write, ifid_flush, idex_flush, freeze, sel};
    total++;
    if (got !== ctl) begin
      bad++;
      $display("FAIL %s ctl got=%b want=%b", nm, got, ctl);
    end
    total++;
    if (stall_cnt !== es || flush_cnt !== ef) begin
      bad++;
      $display("FAIL %s cnt got stall=%0d flush=%0d want stall=%0d flush=%0d",
               nm, stall_cnt, flush_cnt, es, ef);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    vt[0] = '{"idle",       5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, C_EN,    4'd0, 4'd0};
    vt[1] = '{"lw_rs1",     5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_STALL, 4'd0, 4'd0};
    vt[2] = '{"lw_gone",    5'd5, 5'd2, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, C_EN,    4'd1, 4'd0};
    vt[3] = '{"rd_x0",      5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_EN,    4'd1, 4'd0};
    vt[4] = '{"rs2_unused", 5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_EN,    4'd1, 4'd0};
    vt[5] = '{"rs2_used",   5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_STALL, 4'd1, 4'd0};
    vt[6] = '{"br_over_lu", 5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_FLUSH, 4'd2, 4'd0};
    vt[7] = '{"after_br",   5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, C_EN,    4'd2, 4'd1};
    vt[8] = '{"clr",        5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, C_EN,    4'd2, 4'd1};
    vt[9] = '{"after_clr",  5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, C_EN,    4'd0, 4'd0};

    // Reset held with hazardous inputs: outputs forced to the neutral pattern.
    rst = 1'b1; rs1 = 5'd5; rs2 = 5'd0; uses_rs2 = 1'b0; memread = 1'b1; rd = 5'd5;
    br = 1'b1; busy = 1'b1; clr = 1'b0;
    @(posedge clk); #1;
    cyc("reset", 1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, C_EN, 4'd0, 4'd0);

    for (int i = 0; i < 10; i++)
      cyc(vt[i].nm, 1'b0, vt[i].rs1, vt[i].rs2, vt[i].uses, vt[i].mr, vt[i].rd,
          vt[i].br, vt[i].busy, vt[i].clr, vt[i].ctl, vt[i].es, vt[i].ef);

    // Freeze for three cycles with the branch held in EX: one deferred flush.
    cyc("frz0",   1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, C_FRZ,   4'd0, 4'd0);
    cyc("frz1",   1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, C_FRZ,   4'd0, 4'd0);
    cyc("frz2",   1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, C_FRZ,   4'd0, 4'd0);
    cyc("mw_exit",1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, C_EN,    4'd0, 4'd0);
    cyc("fpend",  1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, C_FLUSH, 4'd0, 4'd0);
    cyc("post_fp",1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, C_EN,    4'd0, 4'd1);

    // Reset during MEM_WAIT with pend set: pend dropped, no later flush.
    cyc("rb_frz", 1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, C_FRZ,   4'd0, 4'd1);
    cyc("rb_rst", 1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, C_EN,    4'd0, 4'd1);
    cyc("rb_idle",1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, C_EN,    4'd0, 4'd0);
    cyc("rb_frz2",1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, C_FRZ,   4'd0, 4'd0);
    cyc("rb_exit",1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, C_EN,    4'd0, 4'd0);
    cyc("rb_nofl",1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, C_EN,    4'd0, 4'd0);

    // Twenty stall cycles saturate the 4-bit counter at 15; clear beats the stall.
    for (int i = 0; i < 20; i++)
      cyc("sat_stall", 1'b0, 5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_STALL,
          (i < 15) ? 4'(i) : 4'd15, 4'd0);
    cyc("sat_clr",  1'b0, 5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, C_STALL, 4'd15, 4'd0);
    cyc("post_clr", 1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, C_EN,    4'd0,  4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
